// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin arbiter that shares one UART TX-buffer stream
// among NREQ byte requesters. The grant is held until the owner's tlast beat is accepted,
// or until the owner has been idle for LOCK_TIMEOUT consecutive cycles.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned UART_DLEN    = 8,
  parameter int unsigned LOCK_TIMEOUT = 16,
  localparam int unsigned IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           i_req_tvalid,
  output logic [NREQ-1:0]           o_req_tready,
  input  logic [NREQ*UART_DLEN-1:0] i_req_tdata,
  input  logic [NREQ-1:0]           i_req_tlast,
  output logic                      o_txb_tvalid,
  input  logic                      i_txb_tready,
  output logic [UART_DLEN-1:0]      o_txb_tdata,
  output logic                      o_grant_valid,
  output logic [IDW-1:0]            o_grant_id,
  output logic                      o_abort
);

  // Counter only needs to reach LOCK_TIMEOUT-1; the expiring cycle is decoded directly.
  localparam int unsigned CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntLast = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         gid_q, gid_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   txv_q, txv_d;
  logic [UART_DLEN-1:0]   txd_q, txd_d;

  logic [UART_DLEN-1:0]   req_data [NREQ];
  logic                   scan_hit;
  logic [IDW-1:0]         scan_id;
  logic [IDW-1:0]         scan_idx;
  logic                   locked;
  logic                   owner_valid;
  logic                   owner_last;
  logic [UART_DLEN-1:0]   owner_data;
  logic                   owner_ready;
  logic                   accept;
  logic                   timeout_hit;

  // Round-robin successor with explicit wrap so non-power-of-two NREQ works.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_data[i] = i_req_tdata[i*UART_DLEN +: UART_DLEN];
  end

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    scan_hit = 1'b0;
    scan_id  = ptr_q;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!scan_hit && i_req_tvalid[scan_idx]) begin
        scan_hit = 1'b1;
        scan_id  = scan_idx;
      end
    end
  end

  assign locked      = (state_q == StLocked);
  assign owner_valid = i_req_tvalid[gid_q];
  assign owner_last  = i_req_tlast[gid_q];
  assign owner_data  = req_data[gid_q];
  // Owner may push whenever the output register is empty or draining this cycle.
  assign owner_ready = locked & (~txv_q | i_txb_tready);
  assign accept      = owner_ready & owner_valid;
  assign timeout_hit = (LOCK_TIMEOUT != 0) && locked && !owner_valid && (cnt_q == CntLast);

  // Ready is steered only to the current owner.
  always_comb begin
    o_req_tready = '0;
    if (locked) begin
      o_req_tready[gid_q] = owner_ready;
    end
  end

  // Arbitration FSM, idle-timeout counter and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (scan_hit) begin
          state_d = StLocked;
          gid_d   = scan_id;
        end
      end
      StLocked: begin
        if (owner_valid) begin
          cnt_d = '0;
        end else if (LOCK_TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
        // An accepted beat implies owner_valid, so tlast and timeout never coincide.
        if (accept && owner_last) begin
          state_d = StIdle;
          ptr_d   = next_id(gid_q);
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = StIdle;
          ptr_d   = next_id(gid_q);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered output stage: load on accept, drain when the buffer takes the byte.
  always_comb begin
    txv_d = txv_q;
    txd_d = txd_q;
    if (accept) begin
      txv_d = 1'b1;
      txd_d = owner_data;
    end else if (i_txb_tready) begin
      txv_d = 1'b0;
    end
  end

  // State register; reset drops any pending byte and the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
    end
  end

  assign o_txb_tvalid  = txv_q;
  assign o_txb_tdata   = txd_q;
  assign o_grant_valid = locked;
  assign o_grant_id    = gid_q;
  assign o_abort       = timeout_hit;

endmodule
